// File: rtl/pipeline_regs.sv
// Shared ID/EX and EX/MEM pipeline register layouts, ALU op codes and EX-stage FSM states.
// Pure type/constant package; no logic, no latency, no flow control.
package pipeline_regs;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC, ALU_JAL, ALU_JALR,
        ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;

    typedef enum logic [1:0] {
        EX_IDLE,
        EX_DIV,
        EX_DONE
    } ex_state_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        logic        alu_src;      // operand_b = imm instead of rs2_data
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_width;
        logic        mem_unsigned;
        logic        mem_to_reg;
    } id_ex_reg_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_width;
        logic        mem_unsigned;
        logic        mem_to_reg;
    } ex_mem_reg_t;

    function automatic logic is_div_op(input alu_op_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative radix-2 unsigned divider: one quotient bit per cycle, DIV_ITER cycles after start.
// done pulses combinationally on the last iteration with final quotient/remainder; kill aborts.
module ex_divider #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        kill,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [5:0]  cnt_q;
    logic        run_q;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        ge;

    // quotient/remainder show the result of the step taken this cycle
    always_comb begin
        rem_sh    = {rem_q, quo_q[31]};
        diff      = rem_sh - {1'b0, dvs_q};
        ge        = ~diff[32];
        remainder = ge ? diff[31:0] : rem_sh[31:0];
        quotient  = {quo_q[30:0], ge};
        done      = run_q && (cnt_q == 6'(DIV_ITER - 1));
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (run_q) begin
            rem_q <= remainder;
            quo_q <= quotient;
            cnt_q <= cnt_q + 6'd1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage (ALU/branch/MUL combinational; DIV/REM iterative when EX_DIV_EN is defined).
// Zero latency except divides (33 cycles, 1 for special cases) held via ex_busy; stall extends EX_DONE.
module ex_stage
    import pipeline_regs::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  id_ex_reg_t  id_ex_reg,
    output ex_mem_reg_t ex_mem_next,
    output logic        ex_busy,
    output logic        branch_taken,
    output logic [31:0] branch_target
);

    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic [31:0]        alu_res;
    logic [31:0]        target;
    logic [32:0]        mul_a;
    logic [32:0]        mul_b;
    logic signed [65:0] mul_p;
    logic               br_cond;
    logic               is_div;
    ex_mem_reg_t        alu_next;
    ex_mem_reg_t        nxt;
    logic               busy_s;
    logic               taken_s;

    always_comb begin
        op_a    = id_ex_reg.rs1_data;
        op_b    = id_ex_reg.alu_src ? id_ex_reg.imm : id_ex_reg.rs2_data;
        is_div  = is_div_op(id_ex_reg.alu_op);
        mul_a   = {(id_ex_reg.alu_op inside {ALU_MULH, ALU_MULHSU}) & op_a[31], op_a};
        mul_b   = {(id_ex_reg.alu_op == ALU_MULH) & op_b[31], op_b};
        mul_p   = $signed(mul_a) * $signed(mul_b);
        alu_res = '0;
        br_cond = 1'b0;
        case (id_ex_reg.alu_op)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_SLL:    alu_res = op_a << op_b[4:0];
            ALU_SLT:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_res = {31'b0, op_a < op_b};
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SRL:    alu_res = op_a >> op_b[4:0];
            ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_OR:     alu_res = op_a | op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_LUI:    alu_res = id_ex_reg.imm;
            ALU_AUIPC:  alu_res = id_ex_reg.pc + id_ex_reg.imm;
            ALU_JAL, ALU_JALR: begin
                alu_res = id_ex_reg.pc + 32'd4;
                br_cond = 1'b1;
            end
            ALU_BEQ:    br_cond = id_ex_reg.rs1_data == id_ex_reg.rs2_data;
            ALU_BNE:    br_cond = id_ex_reg.rs1_data != id_ex_reg.rs2_data;
            ALU_BLT:    br_cond = $signed(id_ex_reg.rs1_data) <  $signed(id_ex_reg.rs2_data);
            ALU_BGE:    br_cond = $signed(id_ex_reg.rs1_data) >= $signed(id_ex_reg.rs2_data);
            ALU_BLTU:   br_cond = id_ex_reg.rs1_data <  id_ex_reg.rs2_data;
            ALU_BGEU:   br_cond = id_ex_reg.rs1_data >= id_ex_reg.rs2_data;
            ALU_MUL:    alu_res = mul_p[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: alu_res = mul_p[63:32];
            default:    alu_res = '0;
        endcase
        target = (id_ex_reg.alu_op == ALU_JALR)
               ? ((id_ex_reg.rs1_data + id_ex_reg.imm) & 32'hFFFF_FFFE)
               : (id_ex_reg.pc + id_ex_reg.imm);

        alu_next.valid        = id_ex_reg.valid & ~flush;
        alu_next.alu_result   = alu_res;
        alu_next.rs2_data     = id_ex_reg.rs2_data;
        alu_next.rd           = id_ex_reg.rd;
        alu_next.reg_write    = id_ex_reg.reg_write;
        alu_next.mem_read     = id_ex_reg.mem_read;
        alu_next.mem_write    = id_ex_reg.mem_write;
        alu_next.mem_width    = id_ex_reg.mem_width;
        alu_next.mem_unsigned = id_ex_reg.mem_unsigned;
        alu_next.mem_to_reg   = id_ex_reg.mem_to_reg;
    end

`ifdef EX_DIV_EN
    ex_state_t   state_q, state_d;
    ex_mem_reg_t hold_q, hold_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic        is_rem_q, is_rem_d;
    logic        div_signed;
    logic        div_rem_op;
    logic        div_special;
    logic [31:0] special_res;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [31:0] q_signed;
    logic [31:0] r_signed;

    always_comb begin
        div_signed = id_ex_reg.alu_op inside {ALU_DIV, ALU_REM};
        div_rem_op = id_ex_reg.alu_op inside {ALU_REM, ALU_REMU};
        a_abs = (div_signed & id_ex_reg.rs1_data[31]) ? -id_ex_reg.rs1_data : id_ex_reg.rs1_data;
        b_abs = (div_signed & id_ex_reg.rs2_data[31]) ? -id_ex_reg.rs2_data : id_ex_reg.rs2_data;
        div_special = 1'b0;
        special_res = '0;
        if (id_ex_reg.rs2_data == 32'd0) begin
            div_special = 1'b1;
            special_res = div_rem_op ? id_ex_reg.rs1_data : DIV_BY_ZERO_Q;
        end else if (div_signed && id_ex_reg.rs1_data == 32'h8000_0000
                     && id_ex_reg.rs2_data == 32'hFFFF_FFFF) begin
            div_special = 1'b1;
            special_res = div_rem_op ? 32'd0 : 32'h8000_0000;
        end
        q_signed = neg_q_q ? -div_quo : div_quo;
        r_signed = neg_r_q ? -div_rem : div_rem;
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        is_rem_d  = is_rem_q;
        div_start = 1'b0;
        nxt       = alu_next;
        busy_s    = 1'b0;
        taken_s   = 1'b0;
        case (state_q)
            EX_IDLE: begin
                taken_s = br_cond & id_ex_reg.valid & ~flush;
                if (is_div && id_ex_reg.valid && !flush) begin
                    busy_s            = 1'b1;
                    nxt.valid         = 1'b0;
                    hold_d            = alu_next;
                    hold_d.valid      = 1'b1;
                    hold_d.alu_result = special_res;
                    neg_q_d  = div_signed & (id_ex_reg.rs1_data[31] ^ id_ex_reg.rs2_data[31]);
                    neg_r_d  = div_signed & id_ex_reg.rs1_data[31];
                    is_rem_d = div_rem_op;
                    if (div_special) begin
                        state_d = EX_DONE;
                    end else begin
                        div_start = 1'b1;
                        state_d   = EX_DIV;
                    end
                end
            end
            EX_DIV: begin
                busy_s    = 1'b1;
                nxt       = hold_q;
                nxt.valid = 1'b0;
                if (div_done) begin
                    hold_d.alu_result = is_rem_q ? r_signed : q_signed;
                    state_d           = EX_DONE;
                end
            end
            EX_DONE: begin
                nxt = hold_q;
                if (!stall) begin
                    state_d = EX_IDLE;
                end
            end
            default: state_d = EX_IDLE;
        endcase
        // flush wins over every state; the divider is killed alongside
        if (flush) begin
            state_d   = EX_IDLE;
            busy_s    = 1'b0;
            nxt.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EX_IDLE;
            hold_q   <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            is_rem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            is_rem_q <= is_rem_d;
        end
    end

    ex_divider #(
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .kill      (flush),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`else
    // Divide ops fall through the ALU with a zero result and keep reg_write intact.
    logic unused_cfg;
    assign unused_cfg = ^{clk, stall, is_div, 6'(DIV_ITER)};

    always_comb begin
        nxt     = alu_next;
        busy_s  = 1'b0;
        taken_s = br_cond & id_ex_reg.valid & ~flush;
    end
`endif

    assign ex_mem_next   = rst ? '0 : nxt;
    assign ex_busy       = rst ? 1'b0 : busy_s;
    assign branch_taken  = rst ? 1'b0 : taken_s;
    assign branch_target = rst ? 32'd0 : target;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expectations.
module tb_ex_stage;
    import pipeline_regs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    id_ex_reg_t  id_ex_reg;
    ex_mem_reg_t ex_mem_next;
    logic        ex_busy;
    logic        branch_taken;
    logic [31:0] branch_target;

    int vectors     = 0;
    int miscompares = 0;

    ex_stage #(
        .DIV_ITER (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .id_ex_reg     (id_ex_reg),
        .ex_mem_next   (ex_mem_next),
        .ex_busy       (ex_busy),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm);
        id_ex_reg           = '0;
        id_ex_reg.valid     = 1'b1;
        id_ex_reg.alu_op    = op;
        id_ex_reg.rs1_data  = a;
        id_ex_reg.rs2_data  = b;
        id_ex_reg.pc        = pc;
        id_ex_reg.imm       = imm;
        id_ex_reg.rd        = 5'd5;
        id_ex_reg.reg_write = 1'b1;
    endtask

    task automatic run_div(input string tag, input alu_op_t op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input int cycles);
        int n = 0;
        next_cycle();
        set_op(op, a, b, 32'd0, 32'd0);
        #1;
        while (ex_busy && n < 40) begin
            n++;
            next_cycle();
            #1;
        end
        chk({tag, "_busy_cycles"}, 80'(n), 80'(cycles));
        chk({tag, "_result"}, ex_mem_next.alu_result, res);
        chk({tag, "_valid"}, ex_mem_next.valid, 1'b1);
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        set_op(ALU_ADD, 32'd1, 32'd2, 32'd0, 32'd0);
        next_cycle();
        #1;
        chk("rst_exmem", ex_mem_next, 80'd0);
        chk("rst_busy", ex_busy, 1'b0);
        chk("rst_target", branch_target, 32'd0);
        next_cycle();
        rst = 1'b0;

        set_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
        #1;
        chk("add_result", ex_mem_next.alu_result, 32'h8000_0000);
        chk("add_valid", ex_mem_next.valid, 1'b1);
        chk("add_busy", ex_busy, 1'b0);
        chk("add_rd", ex_mem_next.rd, 5'd5);

        next_cycle();
        set_op(ALU_BLT, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'h20);
        #1;
        chk("blt_taken", branch_taken, 1'b1);
        chk("blt_target", branch_target, 32'h120);
        flush = 1'b1;
        #1;
        chk("blt_flush_taken", branch_taken, 1'b0);
        chk("blt_flush_valid", ex_mem_next.valid, 1'b0);
        flush = 1'b0;

        next_cycle();
        set_op(ALU_BGEU, 32'd1, 32'd2, 32'h100, 32'h20);
        #1;
        chk("bgeu_not_taken", branch_taken, 1'b0);
        set_op(ALU_SUB, 32'd5, 32'd7, 32'd0, 32'd0);
        #1;
        chk("sub", ex_mem_next.alu_result, 32'hFFFF_FFFE);
        set_op(ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
        #1;
        chk("sra", ex_mem_next.alu_result, 32'hF800_0000);
        set_op(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
        #1;
        chk("sltu", ex_mem_next.alu_result, 32'd1);
        set_op(ALU_ADD, 32'd10, 32'd99, 32'd0, 32'd5);
        id_ex_reg.alu_src = 1'b1;
        #1;
        chk("addi", ex_mem_next.alu_result, 32'd15);
        set_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        #1;
        chk("mul", ex_mem_next.alu_result, 32'd1);
        set_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        #1;
        chk("mulhu", ex_mem_next.alu_result, 32'hFFFF_FFFE);
        set_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        #1;
        chk("mulhsu", ex_mem_next.alu_result, 32'hFFFF_FFFF);
        set_op(ALU_MULH, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        #1;
        chk("mulh", ex_mem_next.alu_result, 32'hFFFF_FFFF);
        set_op(ALU_LUI, 32'd0, 32'd0, 32'd0, 32'h1234_5000);
        #1;
        chk("lui", ex_mem_next.alu_result, 32'h1234_5000);
        set_op(ALU_AUIPC, 32'd0, 32'd0, 32'h100, 32'h1000);
        #1;
        chk("auipc", ex_mem_next.alu_result, 32'h1100);
        set_op(ALU_JAL, 32'd0, 32'd0, 32'h200, 32'h40);
        #1;
        chk("jal_link", ex_mem_next.alu_result, 32'h204);
        chk("jal_target", branch_target, 32'h240);
        set_op(ALU_JALR, 32'h301, 32'd0, 32'h200, 32'd4);
        #1;
        chk("jalr_taken", branch_taken, 1'b1);
        chk("jalr_target", branch_target, 32'h304);

`ifdef EX_DIV_EN
        run_div("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_div("rem", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_div("divu_zero", ALU_DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_div("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_div("rem_zero", ALU_REM, 32'd5, 32'd0, 32'd5, 1);
        run_div("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            #1;
            chk("stall_hold_result", ex_mem_next.alu_result, 32'd14);
            chk("stall_hold_valid", ex_mem_next.valid, 1'b1);
        end
        stall = 1'b0;
        next_cycle();
        set_op(ALU_ADD, 32'd2, 32'd3, 32'd0, 32'd0);
        #1;
        chk("after_stall_add", ex_mem_next.alu_result, 32'd5);
        chk("after_stall_busy", ex_busy, 1'b0);

        // flush mid-divide
        next_cycle();
        set_op(ALU_DIV, 32'd1000, 32'd3, 32'd0, 32'd0);
        repeat (10) next_cycle();
        #1;
        chk("mid_div_busy", ex_busy, 1'b1);
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        id_ex_reg.valid = 1'b0;
        #1;
        chk("flush_busy", ex_busy, 1'b0);
        chk("flush_valid", ex_mem_next.valid, 1'b0);
        set_op(ALU_ADD, 32'd20, 32'd22, 32'd0, 32'd0);
        #1;
        chk("flush_add", ex_mem_next.alu_result, 32'd42);
        chk("flush_add_valid", ex_mem_next.valid, 1'b1);

        // reset mid-divide
        next_cycle();
        set_op(ALU_DIVU, 32'd1000, 32'd3, 32'd0, 32'd0);
        repeat (10) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        id_ex_reg.valid = 1'b0;
        #1;
        chk("rst_div_busy", ex_busy, 1'b0);
        chk("rst_div_valid", ex_mem_next.valid, 1'b0);
        set_op(ALU_ADD, 32'd7, 32'd8, 32'd0, 32'd0);
        #1;
        chk("rst_add", ex_mem_next.alu_result, 32'd15);

        // flush coincident with divide entry
        next_cycle();
        set_op(ALU_DIV, 32'd9, 32'd3, 32'd0, 32'd0);
        flush = 1'b1;
        #1;
        chk("entry_flush_busy", ex_busy, 1'b0);
        next_cycle();
        flush = 1'b0;
        id_ex_reg.valid = 1'b0;
        #1;
        chk("entry_flush_next_busy", ex_busy, 1'b0);
`else
        next_cycle();
        set_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        #1;
        chk("nodiv_result", ex_mem_next.alu_result, 32'd0);
        chk("nodiv_valid", ex_mem_next.valid, 1'b1);
        chk("nodiv_busy", ex_busy, 1'b0);
        chk("nodiv_reg_write", ex_mem_next.reg_write, 1'b1);
        next_cycle();
        #1;
        chk("nodiv_next_busy", ex_busy, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RV32IM pipeline. It consumes the ID/EX pipeline register and resolves branches. It produces the EX/MEM next-state bundle that the memory stage registers. Single-cycle ALU, branch and multiply operations complete combinationally; DIV/DIVU/REM/REMU run on an iterative radix-2 divider, during which the stage holds the pipeline via `ex_busy`.

## Interface
Parameters:
- `DIV_ITER`, default 32: divider iterations, one quotient bit per cycle; legal value 32 only.

Ports:
- `clk`  in  1  system clock, one clock for the whole block.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  downstream hold; EX/MEM register will not capture this cycle.
- `flush`  in  1  kill the instruction currently in EX (branch/trap redirect).
- `id_ex_reg`  in  `id_ex_reg_t`  decoded instruction with forwarded `rs1_data`/`rs2_data`, `pc`, `imm`, `alu_op`, memory controls, `valid`.
- `ex_mem_next`  out  `ex_mem_reg_t`  carries `alu_result`, `rs2_data`, `rd`, `reg_write`, `mem_read`, `mem_write`, `mem_width`, `mem_unsigned`, `mem_to_reg` and `valid`.
- `ex_busy`  out  1  stall request to the hazard unit (freezes IF/ID/EX).
- `branch_taken`  out  1  redirect request.
- `branch_target`  out  32  redirect PC.

## Operation
- State machine `ex_state_t`: `EX_IDLE`, `EX_DIV`, `EX_DONE`.
- EX_IDLE, non-divide op: `ex_mem_next` driven combinationally from the ALU, with `valid = id_ex_reg.valid & ~flush`. `ex_busy = 0`.
- ALU: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; shift amount is `operand_b[4:0]`. LUI passes `imm`; AUIPC computes `pc+imm`; JAL/JALR write `pc+4`.
- MUL/MULH/MULHSU/MULHU: 33x33 signed product with operands sign/zero-extended per op. MUL returns `[31:0]`; the high variants return `[63:32]`.
- Branches: BEQ/BNE/BLT/BGE/BLTU/BGEU compare `rs1_data`/`rs2_data`. Target is `pc+imm`; JALR target is `(rs1_data+imm) & ~1`. `branch_taken` is asserted only when the branch is taken, `valid=1`, `flush=0` and state is EX_IDLE.
- Divide entry, EX_IDLE with a valid divide op and no flush:
  - `ex_busy = 1`, `ex_mem_next.valid = 0`.
  - Absolute values, sign flags and op are latched; counter is cleared; next state is EX_DIV.
- EX_DIV:
  - One shift-subtract per cycle; `ex_busy = 1`; counter increments.
  - At count `DIV_ITER-1`, signs are applied and the result is latched; next state is EX_DONE.
- EX_DONE:
  - `ex_mem_next` carries the latched result with `valid=1`; `ex_busy = 0`.
  - Leave for EX_IDLE when `stall=0`; otherwise hold, with the result and `valid` stable.
- Special cases bypass iteration (EX_IDLE → EX_DONE directly):
  - Divide by zero: quotient `0xFFFFFFFF`, remainder = dividend.
  - Signed overflow (`0x80000000 / -1`): quotient `0x80000000`, remainder 0.
- Sign rules: quotient is negated iff the operand signs differ (signed ops only); remainder takes the dividend's sign.
- `flush` in any state: next state EX_IDLE, `ex_busy = 0`, `ex_mem_next.valid = 0`, and the divider result is discarded.
- During reset: state EX_IDLE, counter 0, and all outputs are 0 (`ex_mem_next = '0`).

## Timing
- Non-divide ops have zero added latency: the result is in `ex_mem_next` in the same cycle the instruction is in EX.
- Normal divide accepted in cycle T:
  - `ex_busy` is high for cycles T..T+32.
  - Result is valid in cycle T+33 with `ex_busy` low; the EX/MEM register captures it at the end of T+33 if `stall=0`.
- Special-case divide: busy in cycle T only; result in cycle T+1.
- `stall` during EX_DIV has no effect on iteration; it only extends EX_DONE.
- A flush coincident with divide entry suppresses entry and the state stays EX_IDLE.
- Reset mid-divide: state is EX_IDLE in the next cycle with no output.

## Configuration
- `EX_DIV_EN` defined: divider and states EX_DIV/EX_DONE are compiled in, with the behaviour above.
- `EX_DIV_EN` undefined: no divider and no state register. Divide ops complete in one cycle with `alu_result = 0` and `ex_busy` tied 0; `reg_write` is preserved so that x0 semantics are unchanged.

## Structure
- Shared package (`pipeline_regs`): `id_ex_reg_t`, `ex_mem_reg_t`, the `alu_op_t` enum including the MUL*/DIV*/REM* codes, `ex_state_t`, and the `DIV_BY_ZERO_Q` constant.
- Sub-module `ex_divider`: iterative unsigned core with ports `start`, `dividend`, `divisor`, `kill`, `done`, `quotient`, `remainder`. Sign handling and special cases stay in `ex_stage`.

## Test plan
- ADD with `rs1=0x7FFFFFFF`, `rs2=1` → `alu_result=0x80000000`, `valid=1` same cycle, `ex_busy=0`.
- BLT with `rs1=-1`, `rs2=0`, `pc=0x100`, `imm=0x20` → `branch_taken=1`, `branch_target=0x120`. The same inputs with `flush=1` → `branch_taken=0`, `valid=0`.
- DIV with `-7 / 2` → `ex_busy` high 33 cycles, then quotient `0xFFFFFFFD`. REM with the same operands → `0xFFFFFFFF`.
- DIVU by 0 → `0xFFFFFFFF` at T+1. DIV `0x80000000 / 0xFFFFFFFF` → `0x80000000`. REM by 0 with dividend 5 → 5.
- DIVU `100 / 7` with `stall` held high for 5 cycles after done → result 14 stays stable with `valid=1` through the stall, and the state is EX_IDLE one cycle after release.
- Flush at cycle T+10 of a divide → `ex_busy=0` and `valid=0` next cycle. A following ADD completes normally. Same check with `rst` instead of flush.
